// File: rtl/mem_access_pkg.sv
// Shared constants, state encoding and func3 decode helpers for the
// memory-access stage.
package mem_access_pkg;

   localparam logic [6:0]  OP_LOAD    = 7'b0000011;
   localparam logic [6:0]  OP_STORE   = 7'b0100011;

   localparam logic [2:0]  F3_LB      = 3'd0;
   localparam logic [2:0]  F3_LH      = 3'd1;
   localparam logic [2:0]  F3_LW      = 3'd2;
   localparam logic [2:0]  F3_LBU     = 3'd4;
   localparam logic [2:0]  F3_LHU     = 3'd5;
   localparam logic [2:0]  F3_SB      = 3'd0;
   localparam logic [2:0]  F3_SH      = 3'd1;
   localparam logic [2:0]  F3_SW      = 3'd2;

   localparam logic        RST_ENABLE = 1'b1;
   localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_STORE = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   function automatic logic f3_supported(input logic [6:0] op, input logic [2:0] f3);
      if (op == OP_LOAD)
         return f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
      if (op == OP_STORE)
         return f3 inside {F3_SB, F3_SH, F3_SW};
      return 1'b0;
   endfunction

   // Index of the final byte of the transfer (N-1).
   function automatic logic [1:0] last_byte(input logic [2:0] f3);
      case (f3[1:0])
         2'd0:    return 2'd0;
         2'd1:    return 2'd1;
         default: return 2'd3;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_if.sv
// EX/MEM request, byte-wide RAM port and MEM/WB result bundle of the
// memory-access stage.
interface mem_access_if;
   logic        in_valid;
   logic [6:0]  opcode_i;
   logic [2:0]  func3_i;
   logic [31:0] mem_addr_i;
   logic [31:0] store_data_i;
   logic [4:0]  wd_i;
   logic        wreg_i;
   logic [31:0] wdata_i;

   logic [31:0] mem_a;
   logic        mem_wr;
   logic [7:0]  mem_dout;
   logic [7:0]  mem_din;

   logic        stall_o;
   logic        out_valid;
   logic [4:0]  wd_o;
   logic        wreg_o;
   logic [31:0] wdata_o;

   modport master (
      output in_valid, opcode_i, func3_i, mem_addr_i, store_data_i, wd_i, wreg_i, wdata_i,
      output mem_din,
      input  mem_a, mem_wr, mem_dout,
      input  stall_o, out_valid, wd_o, wreg_o, wdata_o
   );

   modport slave (
      input  in_valid, opcode_i, func3_i, mem_addr_i, store_data_i, wd_i, wreg_i, wdata_i,
      input  mem_din,
      output mem_a, mem_wr, mem_dout,
      output stall_o, out_valid, wd_o, wreg_o, wdata_o
   );
endinterface

// File: rtl/mem_access_load_ext.sv
// Sign/zero extension of assembled load data according to func3.
module load_ext
   import mem_access_pkg::*;
(
   input  logic [31:0] data_i,
   input  logic [2:0]  func3_i,
   output logic [31:0] data_o
);
   always_comb begin
      data_o = data_i;
      case (func3_i)
         F3_LB:   data_o = {{24{data_i[7]}}, data_i[7:0]};
         F3_LH:   data_o = {{16{data_i[15]}}, data_i[15:0]};
         F3_LBU:  data_o = {24'd0, data_i[7:0]};
         F3_LHU:  data_o = {16'd0, data_i[15:0]};
         default: data_o = data_i;
      endcase
   end
endmodule

// File: rtl/mem_access.sv
// Memory-access stage: serialises loads/stores over a byte-wide RAM port,
// little-endian, stalling upstream while a transfer is in flight.
module mem_access
   import mem_access_pkg::*;
#(
   parameter int RAM_LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   mem_access_if.slave bus
);
   localparam logic [1:0] LAT = 2'(RAM_LAT);

   state_e      state;
   logic [1:0]  idx, last_q, idx_nx, cap;
   logic        st_q, wreg_q;
   logic [2:0]  f3_q;
   logic [4:0]  wd_q;
   logic [31:0] addr_q, sdata_q, buf_q, assembled, ext_data;
   logic        is_mem, mem_ok;

   always_comb begin
      is_mem      = (bus.opcode_i == OP_LOAD) || (bus.opcode_i == OP_STORE);
      mem_ok      = bus.in_valid && f3_supported(bus.opcode_i, bus.func3_i);
      idx_nx      = idx + 2'd1;
      cap         = idx - LAT;
      bus.stall_o = (rst != RST_ENABLE) &&
                    ((state == ST_IDLE && mem_ok) || state == ST_LOAD || state == ST_STORE);
   end

   // The final byte is still on mem_din during DONE; merge it before extending.
   always_comb begin
      assembled = buf_q;
      assembled[{last_q, 3'b000} +: 8] = bus.mem_din;
   end

   load_ext u_load_ext (
      .data_i  (assembled),
      .func3_i (f3_q),
      .data_o  (ext_data)
   );

   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         state         <= ST_IDLE;
         idx           <= 2'd0;
         last_q        <= 2'd0;
         st_q          <= 1'b0;
         wreg_q        <= 1'b0;
         f3_q          <= 3'd0;
         wd_q          <= 5'd0;
         addr_q        <= ZERO_WORD;
         sdata_q       <= ZERO_WORD;
         buf_q         <= ZERO_WORD;
         bus.mem_a     <= ZERO_WORD;
         bus.mem_wr    <= 1'b0;
         bus.mem_dout  <= 8'd0;
         bus.out_valid <= 1'b0;
         bus.wd_o      <= 5'd0;
         bus.wreg_o    <= 1'b0;
         bus.wdata_o   <= ZERO_WORD;
      end else begin
         bus.mem_a     <= ZERO_WORD;
         bus.mem_wr    <= 1'b0;
         bus.mem_dout  <= 8'd0;
         bus.out_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (mem_ok) begin
                  f3_q      <= bus.func3_i;
                  addr_q    <= bus.mem_addr_i;
                  sdata_q   <= bus.store_data_i;
                  wd_q      <= bus.wd_i;
                  wreg_q    <= bus.wreg_i;
                  st_q      <= (bus.opcode_i == OP_STORE);
                  idx       <= 2'd0;
                  last_q    <= last_byte(bus.func3_i);
                  bus.mem_a <= bus.mem_addr_i;
                  if (bus.opcode_i == OP_STORE) begin
                     state        <= ST_STORE;
                     bus.mem_wr   <= 1'b1;
                     bus.mem_dout <= bus.store_data_i[7:0];
                  end else begin
                     state <= ST_LOAD;
                  end
               end else if (bus.in_valid) begin
                  // Unsupported load/store func3 falls through here with no write-back.
                  bus.out_valid <= 1'b1;
                  bus.wd_o      <= bus.wd_i;
                  bus.wreg_o    <= bus.wreg_i & ~is_mem;
                  bus.wdata_o   <= bus.wdata_i;
               end
            end
            ST_LOAD: begin
               if (idx >= LAT)
                  buf_q[{cap, 3'b000} +: 8] <= bus.mem_din;
               if (idx == last_q) begin
                  state <= ST_DONE;
               end else begin
                  idx       <= idx_nx;
                  bus.mem_a <= addr_q + {30'd0, idx_nx};
               end
            end
            ST_STORE: begin
               if (idx == last_q) begin
                  state <= ST_DONE;
               end else begin
                  idx          <= idx_nx;
                  bus.mem_a    <= addr_q + {30'd0, idx_nx};
                  bus.mem_wr   <= 1'b1;
                  bus.mem_dout <= sdata_q[{idx_nx, 3'b000} +: 8];
               end
            end
            ST_DONE: begin
               bus.out_valid <= 1'b1;
               bus.wd_o      <= wd_q;
               bus.wreg_o    <= st_q ? 1'b0 : wreg_q;
               bus.wdata_o   <= st_q ? ZERO_WORD : ext_data;
               state         <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed steps plus random loads/stores against a
// byte-array memory model.
module tb_mem_access;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_access_if bus();

   mem_access #(.RAM_LAT(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Device RAM (answers the DUT port) and reference memory (expected contents).
   logic [7:0] ram     [1024];
   logic [7:0] ref_mem [1024];
   logic       ram_rdy = 1'b0;

   function automatic logic [7:0] dflt(input logic [9:0] a);
      return a[7:0] ^ {6'd0, a[9:8]} ^ 8'hA5;
   endfunction

   always @(posedge clk) begin
      if (!ram_rdy) begin
         for (int i = 0; i < 1024; i++) ram[i] <= dflt(10'(i));
         ram_rdy <= 1'b1;
      end else if (bus.mem_wr) begin
         ram[bus.mem_a[9:0]] <= bus.mem_dout;
      end
      bus.mem_din <= ram[bus.mem_a[9:0]];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [4:0] wd, input logic wreg,
                        input logic [31:0] wdata);
      bus.in_valid     = 1'b1;
      bus.opcode_i     = op;
      bus.func3_i      = f3;
      bus.mem_addr_i   = addr;
      bus.store_data_i = sdata;
      bus.wd_i         = wd;
      bus.wreg_i       = wreg;
      bus.wdata_i      = wdata;
   endtask

   // Issue one instruction, hold it until the stage consumes it, and check
   // stall, bus and result cycle by cycle against the reference rules.
   task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [4:0] wd, input logic wreg,
                        input logic [31:0] wdata);
      logic        is_ld, is_st, memok, exp_wreg;
      int          n, lat, cons;
      logic [63:0] acc;
      logic [31:0] ev, ak;
      is_ld = (op == 7'h03);
      is_st = (op == 7'h23);
      memok = (is_ld && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5)) ||
              (is_st && f3 <= 3'd2);
      n = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
      ev = wdata;
      exp_wreg = (is_ld || is_st) ? 1'b0 : wreg;
      if (memok && is_ld) begin
         acc = 64'd0;
         for (int k = 0; k < n; k++) begin
            ak = addr + 32'(k);
            acc = acc | (64'(ref_mem[ak[9:0]]) << (8 * k));
         end
         if ((f3 == 3'd0 || f3 == 3'd1) && acc[8*n-1])
            acc = acc + (64'h1_0000_0000 - (64'h1 << (8 * n)));
         ev = acc[31:0];
         exp_wreg = wreg;
      end
      if (memok && is_st) begin
         ev = 32'd0;
         for (int k = 0; k < n; k++) begin
            ak = addr + 32'(k);
            ref_mem[ak[9:0]] = sdata[8*k +: 8];
         end
      end
      lat  = memok ? n + 2 : 1;
      cons = memok ? n + 1 : 0;

      @(posedge clk); #1;
      drive(op, f3, addr, sdata, wd, wreg, wdata);
      for (int t = 0; t <= lat; t++) begin
         @(negedge clk);
         chk($sformatf("stall T%0d", t), 32'(bus.stall_o), 32'(memok && t <= n));
         if (memok && t >= 1 && t <= n) begin
            chk($sformatf("mem_a T%0d", t), bus.mem_a, addr + 32'(t - 1));
            chk($sformatf("mem_wr T%0d", t), 32'(bus.mem_wr), 32'(is_st));
            if (is_st) chk($sformatf("mem_dout T%0d", t), 32'(bus.mem_dout), 32'(sdata[8*(t-1) +: 8]));
         end else begin
            chk($sformatf("mem_wr quiet T%0d", t), 32'(bus.mem_wr), 32'd0);
            chk($sformatf("mem_a quiet T%0d", t), bus.mem_a, 32'd0);
         end
         chk($sformatf("out_valid T%0d", t), 32'(bus.out_valid), 32'(t == lat));
         if (t == lat) begin
            chk("wreg_o", 32'(bus.wreg_o), 32'(exp_wreg));
            chk("wdata_o", bus.wdata_o, ev);
            if (!(memok && is_st)) chk("wd_o", 32'(bus.wd_o), 32'(wd));
         end
         @(posedge clk); #1;
         if (t == cons) bus.in_valid = 1'b0;
      end
      @(negedge clk);
      chk("out_valid pulse end", 32'(bus.out_valid), 32'd0);
   endtask

   initial begin
      logic [6:0]  op;
      logic [31:0] addr;
      for (int i = 0; i < 1024; i++) ref_mem[i] = dflt(10'(i));
      bus.in_valid = 1'b0;
      drive(7'h00, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
      bus.in_valid = 1'b0;

      // Reset: outputs zero, stall low even with a load pending.
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      drive(7'h03, 3'd2, 32'h100, 32'd0, 5'd1, 1'b1, 32'd0);
      @(negedge clk);
      chk("rst stall", 32'(bus.stall_o), 32'd0);
      chk("rst mem_a", bus.mem_a, 32'd0);
      chk("rst mem_wr", 32'(bus.mem_wr), 32'd0);
      chk("rst mem_dout", 32'(bus.mem_dout), 32'd0);
      chk("rst out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst wd_o", 32'(bus.wd_o), 32'd0);
      chk("rst wreg_o", 32'(bus.wreg_o), 32'd0);
      chk("rst wdata_o", bus.wdata_o, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      bus.in_valid = 1'b0;

      // Word round trip: RAM 0x100..0x103 = 78 56 34 12.
      issue(7'h23, 3'd2, 32'h100, 32'h1234_5678, 5'd0, 1'b0, 32'd0);
      issue(7'h03, 3'd2, 32'h100, 32'd0, 5'd7, 1'b1, 32'hDEAD_BEEF);
      // Byte 0x80: sign vs zero extension.
      issue(7'h23, 3'd0, 32'h110, 32'h1234_5680, 5'd0, 1'b1, 32'd0);
      issue(7'h03, 3'd0, 32'h110, 32'd0, 5'd8, 1'b1, 32'd0);
      issue(7'h03, 3'd4, 32'h110, 32'd0, 5'd9, 1'b1, 32'd0);
      // Unaligned halfword store, read back as word.
      issue(7'h23, 3'd1, 32'h203, 32'hABCD_1234, 5'd2, 1'b1, 32'd0);
      issue(7'h03, 3'd2, 32'h203, 32'd0, 5'd10, 1'b1, 32'd0);
      issue(7'h03, 3'd1, 32'h203, 32'd0, 5'd11, 1'b1, 32'd0);
      // Address wrap.
      issue(7'h23, 3'd2, 32'hFFFF_FFFE, 32'hCAFE_BABE, 5'd0, 1'b0, 32'd0);
      issue(7'h03, 3'd2, 32'hFFFF_FFFE, 32'd0, 5'd12, 1'b1, 32'd0);
      // Unsupported func3: pass-through with no write-back, no bus traffic.
      issue(7'h03, 3'd3, 32'h300, 32'd0, 5'd13, 1'b1, 32'h0000_0042);
      issue(7'h23, 3'd6, 32'h300, 32'h5555_5555, 5'd14, 1'b1, 32'h0000_0043);

      // Back-to-back ALU ops: one per cycle, no stall.
      @(posedge clk); #1;
      drive(7'h33, 3'd0, 32'd0, 32'd0, 5'd3, 1'b1, 32'd5);
      @(negedge clk);
      chk("alu0 stall", 32'(bus.stall_o), 32'd0);
      @(posedge clk); #1;
      drive(7'h33, 3'd0, 32'd0, 32'd0, 5'd4, 1'b1, 32'd9);
      @(negedge clk);
      chk("alu1 stall", 32'(bus.stall_o), 32'd0);
      chk("alu0 out_valid", 32'(bus.out_valid), 32'd1);
      chk("alu0 wdata", bus.wdata_o, 32'd5);
      chk("alu0 wd", 32'(bus.wd_o), 32'd3);
      chk("alu0 wreg", 32'(bus.wreg_o), 32'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("alu1 out_valid", 32'(bus.out_valid), 32'd1);
      chk("alu1 wdata", bus.wdata_o, 32'd9);
      chk("alu1 wd", 32'(bus.wd_o), 32'd4);
      @(posedge clk); #1;
      @(negedge clk);
      chk("alu idle out_valid", 32'(bus.out_valid), 32'd0);

      // Reset during T2 of a word load aborts it.
      @(posedge clk); #1;
      drive(7'h03, 3'd2, 32'h100, 32'd0, 5'd15, 1'b1, 32'd0);
      @(negedge clk);
      chk("abort T0 stall", 32'(bus.stall_o), 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("abort T1 mem_a", bus.mem_a, 32'h100);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("abort rst stall", 32'(bus.stall_o), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("abort mem_a", bus.mem_a, 32'd0);
      chk("abort mem_wr", 32'(bus.mem_wr), 32'd0);
      chk("abort mem_dout", 32'(bus.mem_dout), 32'd0);
      chk("abort wd_o", 32'(bus.wd_o), 32'd0);
      chk("abort wreg_o", 32'(bus.wreg_o), 32'd0);
      chk("abort wdata_o", bus.wdata_o, 32'd0);
      for (int c = 0; c < 6; c++) begin
         chk($sformatf("abort no out_valid %0d", c), 32'(bus.out_valid), 32'd0);
         @(posedge clk); #1;
         @(negedge clk);
      end
      issue(7'h03, 3'd2, 32'h100, 32'd0, 5'd16, 1'b1, 32'd0);

      // Random mix of loads, stores, ALU ops and unsupported func3s.
      for (int r = 0; r < 80; r++) begin
         case ($urandom_range(0, 7))
            0, 1, 2: op = 7'h03;
            3, 4, 5: op = 7'h23;
            6:       op = 7'h33;
            default: op = 7'h13;
         endcase
         addr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                            : 32'h300 + 32'($urandom_range(0, 31));
         issue(op, 3'($urandom_range(0, 7)), addr, $urandom, 5'($urandom_range(0, 31)),
               1'($urandom_range(0, 1)), $urandom);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access pipeline stage of the RISC-V core. It sits between the EX/MEM pipeline register and MEM/WB. It takes the execute stage's load/store request (opcode, func3, effective address, store data) and performs it over the core's byte-wide RAM port, one byte per cycle, little-endian. While a memory instruction is in flight it stalls the upstream pipeline. Loads return sign- or zero-extended data; every other instruction's `wdata` passes through unchanged.

## Interface
Parameters:
- `RAM_LAT`, 1: cycles from address presented to `mem_din` valid; fixed at 1, other values unsupported.

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- `clk`  in  1  core clock.
- `rst`  in  1  synchronous, active-high reset.
- Inputs from EX/MEM:
  - `in_valid`  in  1  EX/MEM holds a valid instruction.
  - `opcode_i`  in  7  instruction opcode.
  - `func3_i`  in  3  instruction func3.
  - `mem_addr_i`  in  32  effective address.
  - `store_data_i`  in  32  store data.
  - `wd_i`  in  5  destination register.
  - `wreg_i`  in  1  write-back enable.
  - `wdata_i`  in  32  ALU result.
- Memory port:
  - `mem_a`  out  32  byte address.
  - `mem_wr`  out  1  write strobe.
  - `mem_dout`  out  8  write byte.
  - `mem_din`  in  8  read byte.
- Control and outputs to MEM/WB:
  - `stall_o`  out  1  upstream must hold EX/MEM and earlier.
  - `out_valid`  out  1  output valid.
  - `wd_o`  out  5  destination register.
  - `wreg_o`  out  1  write-back enable.
  - `wdata_o`  out  32  result.

## Operation
- FSM states: IDLE, LOAD, STORE, DONE.
- Byte count N comes from func3:
  - LB/LBU/SB: 1.
  - LH/LHU/SH: 2.
  - LW/SW: 4.
- IDLE, `in_valid` = 0:
  - `out_valid` = 0 on the next cycle.
- IDLE, `in_valid` with a non-memory opcode:
  - Register `wd_i/wreg_i/wdata_i` into outputs; `out_valid` = 1 on the next cycle.
  - `stall_o` = 0.
- IDLE, `in_valid` with OP_LOAD/OP_STORE and a supported func3:
  - Latch the request; byte index i = 0; go to LOAD/STORE.
- Load or store with an unsupported func3 (load 3/6/7, store 3–7):
  - Treated as a non-memory op with `wreg_o` = 0.
  - No bus activity.
- LOAD, each cycle:
  - `mem_a` = addr + i, `mem_wr` = 0.
  - Byte i−1 from `mem_din` is captured into bits [8(i−1)+7 : 8(i−1)].
  - After i = N−1, go to DONE.
- STORE, each cycle:
  - `mem_a` = addr + i, `mem_wr` = 1, `mem_dout` = store_data[8i+7 : 8i].
  - After i = N−1, go to DONE.
- DONE:
  - `mem_wr` = 0.
  - For a load: capture the last byte, then extend (LB/LH sign-extend; LBU/LHU zero-extend; LW unchanged) into `wdata_o`, with `wreg_o` = latched `wreg`.
  - For a store: `wreg_o` = 0, `wdata_o` = 0.
  - `out_valid` = 1 on the next cycle; return to IDLE.
- Address arithmetic is 32-bit modulo; it wraps 0xFFFFFFFF → 0x00000000. No alignment check.
- Outside LOAD/STORE: `mem_a` = 0, `mem_wr` = 0, `mem_dout` = 0.

## Timing
- T0 = cycle a memory instruction is presented in IDLE.
- `stall_o` is combinational: 1 when (IDLE and `in_valid` and supported memory op) or LOAD or STORE; 0 in DONE.
  - EX/MEM advances at the end of DONE, so the instruction is consumed exactly once.
- LOAD/STORE occupy T1..TN; DONE is T(N+1); `out_valid` is seen in T(N+2).
  - LW: output in T6.
  - LB: output in T3.
- Non-memory instruction: output in T1, zero stall; back-to-back issue is one instruction per cycle.
- `out_valid` is a single-cycle pulse per instruction.
- Reset:
  - At the first edge with `rst` = 1, all registered outputs become 0 (`mem_a`, `mem_wr`, `mem_dout`, `out_valid`, `wd_o`, `wreg_o`, `wdata_o`) and the state becomes IDLE.
  - `stall_o` is 0 while `rst` = 1.
- Reset mid-operation aborts the transfer. Bytes already written stay written; no partial result is output.

## Structure
- Shared `defines.vh`: OP_LOAD, OP_STORE, LB/LH/LW/LBU/LHU/SB/SH/SW func3 constants, RstEnable, ZeroWord, FSM state encoding.
- One combinational sub-module, `load_ext`: inputs 32-bit assembled data and func3; output 32-bit extended result.

## Test plan
- LW at 0x100, RAM 0x100..0x103 = 78 56 34 12:
  - `mem_a` = 0x100..0x103 in T1..T4.
  - `stall_o` high T0–T4.
  - T6: `out_valid` = 1, `wdata_o` = 0x12345678.
- LB and LBU at a byte 0x80: `wdata_o` = 0xFFFFFF80 and 0x00000080 respectively.
- SH of 0xABCD1234 at 0x203:
  - T1: `mem_wr` = 1, `mem_a` = 0x203, `mem_dout` = 0x34.
  - T2: `mem_a` = 0x204, `mem_dout` = 0x12.
  - T3: `mem_wr` = 0.
  - T4: `out_valid` = 1, `wreg_o` = 0.
- ADD with `wdata_i` = 5, `wd_i` = 3, followed by another ALU op:
  - `stall_o` = 0.
  - Outputs T1 and T2 with `wdata_o` = 5, `wd_o` = 3 for the first.
- SW at 0xFFFFFFFE: addresses FFFFFFFE, FFFFFFFF, 00000000, 00000001.
- `rst` asserted in T2 of an LW: all outputs 0 next cycle, no `out_valid`; a following LW completes normally.
